// File: rtl/washer_seq_ctrl.sv
// Washing-machine program sequencer: fill/agitate/drain/rinse/spin with programs, second timing, halt/resume.
// Latency: buttons are edge-detected and act on the edge they are sampled; outputs are registered-state decode.
// Backpressure: none; emergency freezes all timing in HALT until a start edge with emergency low.
// Ports: clk, rst (sync, active-high); start/select buttons, emergency level;
//        mode/phase/count status; zheng/fan/inlet/drain actuators, their LED mirrors, ledstop, alarm.
module washer_seq_ctrl #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int CNT_W       = 8,
    parameter int FILL_S      = 10,
    parameter int RUN_S       = 60,
    parameter int PAUSE_S     = 5,
    parameter int WASH_CYC    = 4,
    parameter int RINSE_CYC   = 2,
    parameter int RINSE_N     = 2,
    parameter int DRAIN_S     = 10,
    parameter int SPIN_S      = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             select,
    input  logic             emergency,
    output logic [1:0]       mode,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] count,
    output logic             zheng,
    output logic             fan,
    output logic             inlet,
    output logic             drain,
    output logic             ledzheng,
    output logic             ledfan,
    output logic             ledinlet,
    output logic             leddrain,
    output logic             ledstop,
    output logic             alarm
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_AGIT  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5,
        PH_HALT  = 3'd6
    } phase_t;

    typedef enum logic [1:0] {SUB_FWD, SUB_P1, SUB_REV, SUB_P2} sub_t;

    localparam int PW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int CYC_MAX = (WASH_CYC > RINSE_CYC) ? WASH_CYC : RINSE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int RIN_W   = $clog2(RINSE_N + 1);

    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_D    = CNT_W'(FILL_S);
    localparam logic [CNT_W-1:0] RUN_D     = CNT_W'(RUN_S);
    localparam logic [CNT_W-1:0] PAUSE_D   = CNT_W'(PAUSE_S);
    localparam logic [CNT_W-1:0] DRAIN_D   = CNT_W'(DRAIN_S);
    localparam logic [CNT_W-1:0] SPIN_D    = CNT_W'(SPIN_S);
    localparam logic [CYC_W-1:0] WASH_C    = CYC_W'(WASH_CYC);
    localparam logic [CYC_W-1:0] RINSE_C   = CYC_W'(RINSE_CYC);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [RIN_W-1:0] RIN_INIT  = RIN_W'(RINSE_N);
    localparam logic [RIN_W-1:0] RIN_ONE   = RIN_W'(1);

    phase_t           phase_q, phase_d, halt_ph_q, halt_ph_d;
    sub_t             sub_q, sub_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [RIN_W-1:0] rinse_q, rinse_d;
    logic             rinse_blk_q, rinse_blk_d;   // 0: wash block, 1: rinse block
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             start_q, select_q;
    logic             start_edge, select_edge, tick, enter;

    assign start_edge  = start & ~start_q;
    assign select_edge = select & ~select_q;
    assign tick        = (presc_q == PRESC_MAX);

    // Duration loaded on entry to a step; IDLE/DONE load 0 so count reads 0 there.
    function automatic logic [CNT_W-1:0] step_dur(input phase_t p, input sub_t s);
        case (p)
            PH_FILL:  return FILL_D;
            PH_AGIT:  return (s == SUB_FWD || s == SUB_REV) ? RUN_D : PAUSE_D;
            PH_DRAIN: return DRAIN_D;
            PH_SPIN:  return SPIN_D;
            default:  return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            halt_ph_q   <= PH_IDLE;
            sub_q       <= SUB_FWD;
            cyc_q       <= '0;
            rinse_q     <= '0;
            rinse_blk_q <= 1'b0;
            mode_q      <= 2'd0;
            count_q     <= '0;
            presc_q     <= '0;
            start_q     <= 1'b0;
            select_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            halt_ph_q   <= halt_ph_d;
            sub_q       <= sub_d;
            cyc_q       <= cyc_d;
            rinse_q     <= rinse_d;
            rinse_blk_q <= rinse_blk_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            start_q     <= start;
            select_q    <= select;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        halt_ph_d   = halt_ph_q;
        sub_d       = sub_q;
        cyc_d       = cyc_q;
        rinse_d     = rinse_q;
        rinse_blk_d = rinse_blk_q;
        mode_d      = mode_q;
        count_d     = count_q;
        presc_d     = presc_q;
        enter       = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (start_edge) begin
                    enter       = 1'b1;
                    rinse_d     = RIN_INIT;
                    sub_d       = SUB_FWD;
                    cyc_d       = WASH_C;
                    rinse_blk_d = 1'b0;
                    case (mode_q)
                        2'd0, 2'd1: phase_d = PH_FILL;
                        2'd2: begin
                            phase_d     = PH_FILL;
                            rinse_blk_d = 1'b1;
                            cyc_d       = RINSE_C;
                        end
                        default: phase_d = PH_SPIN;
                    endcase
                end else if (select_edge) begin
                    mode_d = mode_q + 2'd1;
                end
            end

            PH_FILL, PH_AGIT, PH_DRAIN, PH_SPIN: begin
                if (emergency) begin
                    // Everything else holds its value; only the phase parks in HALT.
                    halt_ph_d = phase_q;
                    phase_d   = PH_HALT;
                end else if (!tick) begin
                    presc_d = presc_q + PRESC_ONE;
                end else if (count_q != CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                    presc_d = '0;
                end else begin
                    enter = 1'b1;
                    case (phase_q)
                        PH_FILL: begin
                            phase_d = PH_AGIT;
                            sub_d   = SUB_FWD;
                        end
                        PH_AGIT: begin
                            case (sub_q)
                                SUB_FWD: sub_d = SUB_P1;
                                SUB_P1:  sub_d = SUB_REV;
                                SUB_REV: sub_d = SUB_P2;
                                default: begin
                                    sub_d = SUB_FWD;
                                    if (cyc_q == CYC_ONE) phase_d = PH_DRAIN;
                                    else                  cyc_d   = cyc_q - CYC_ONE;
                                end
                            endcase
                        end
                        PH_DRAIN: begin
                            if (!rinse_blk_q) begin
                                if (mode_q == 2'd1) begin
                                    phase_d = PH_DONE;
                                end else begin
                                    phase_d     = PH_FILL;
                                    rinse_blk_d = 1'b1;
                                    cyc_d       = RINSE_C;
                                end
                            end else if (rinse_q == RIN_ONE) begin
                                phase_d = PH_SPIN;
                            end else begin
                                phase_d = PH_FILL;
                                rinse_d = rinse_q - RIN_ONE;
                                cyc_d   = RINSE_C;
                            end
                        end
                        default: phase_d = PH_DONE;
                    endcase
                end
            end

            PH_HALT: begin
                // Resume without re-entering: count and prescaler continue where frozen.
                if (start_edge && !emergency) phase_d = halt_ph_q;
            end

            PH_DONE: begin
                if (start_edge) begin
                    phase_d = PH_IDLE;
                    enter   = 1'b1;
                end
            end

            default: phase_d = PH_IDLE;
        endcase

        if (enter) begin
            count_d = step_dur(phase_d, sub_d);
            presc_d = '0;
        end
    end

    assign mode     = mode_q;
    assign phase    = phase_q;
    assign count    = count_q;
    assign zheng    = (phase_q == PH_AGIT && sub_q == SUB_FWD) || (phase_q == PH_SPIN);
    assign fan      = (phase_q == PH_AGIT && sub_q == SUB_REV);
    assign inlet    = (phase_q == PH_FILL);
    assign drain    = (phase_q == PH_DRAIN) || (phase_q == PH_SPIN);
    assign ledzheng = zheng;
    assign ledfan   = fan;
    assign ledinlet = inlet;
    assign leddrain = drain;
    assign ledstop  = ~(zheng | fan);
    assign alarm    = (phase_q == PH_DONE);

endmodule

// File: tb/tb_washer_seq_ctrl.sv
// Self-checking bench for washer_seq_ctrl: per-cycle expected output trace queued, popped against the DUT.
// A second instance with a 3-cycle second checks the prescaler.
module tb_washer_seq_ctrl;

    localparam int FILL_S = 2, RUN_S = 3, PAUSE_S = 1, WASH_CYC = 1;
    localparam int RINSE_CYC = 1, RINSE_N = 1, DRAIN_S = 2, SPIN_S = 2;
    localparam logic [2:0] P_IDLE = 3'd0, P_FILL = 3'd1, P_AGIT = 3'd2, P_DRAIN = 3'd3;
    localparam logic [2:0] P_SPIN = 3'd4, P_DONE = 3'd5, P_HALT = 3'd6;
    localparam int AGIT_LEN = 2 * RUN_S + 2 * PAUSE_S;
    localparam int FULL_LEN = FILL_S + WASH_CYC * AGIT_LEN + DRAIN_S
                            + RINSE_N * (FILL_S + RINSE_CYC * AGIT_LEN + DRAIN_S) + SPIN_S;

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] cnt;
        logic z, f, in, dr, lz, lf, li, ld, ls, al;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, select, emergency;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [7:0] count;
    logic zheng, fan, inlet, drain, ledzheng, ledfan, ledinlet, leddrain, ledstop, alarm;

    logic rst3, start3, select3, emergency3;
    logic [1:0] mode3;
    logic [2:0] phase3;
    logic [7:0] count3;
    logic zheng3, fan3, inlet3, drain3, ledzheng3, ledfan3, ledinlet3, leddrain3, ledstop3, alarm3;

    obs_t obs, obs3, exp_o;
    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    washer_seq_ctrl #(.CLK_PER_SEC(1), .CNT_W(8), .FILL_S(FILL_S), .RUN_S(RUN_S), .PAUSE_S(PAUSE_S),
        .WASH_CYC(WASH_CYC), .RINSE_CYC(RINSE_CYC), .RINSE_N(RINSE_N), .DRAIN_S(DRAIN_S), .SPIN_S(SPIN_S))
    u_dut (.clk(clk), .rst(rst), .start(start), .select(select), .emergency(emergency),
        .mode(mode), .phase(phase), .count(count), .zheng(zheng), .fan(fan), .inlet(inlet),
        .drain(drain), .ledzheng(ledzheng), .ledfan(ledfan), .ledinlet(ledinlet),
        .leddrain(leddrain), .ledstop(ledstop), .alarm(alarm));

    washer_seq_ctrl #(.CLK_PER_SEC(3), .CNT_W(8), .FILL_S(FILL_S), .RUN_S(RUN_S), .PAUSE_S(PAUSE_S),
        .WASH_CYC(WASH_CYC), .RINSE_CYC(RINSE_CYC), .RINSE_N(RINSE_N), .DRAIN_S(DRAIN_S), .SPIN_S(SPIN_S))
    u_dut3 (.clk(clk), .rst(rst3), .start(start3), .select(select3), .emergency(emergency3),
        .mode(mode3), .phase(phase3), .count(count3), .zheng(zheng3), .fan(fan3), .inlet(inlet3),
        .drain(drain3), .ledzheng(ledzheng3), .ledfan(ledfan3), .ledinlet(ledinlet3),
        .leddrain(leddrain3), .ledstop(ledstop3), .alarm(alarm3));

    assign obs  = {phase, count, zheng, fan, inlet, drain,
                   ledzheng, ledfan, ledinlet, leddrain, ledstop, alarm};
    assign obs3 = {phase3, count3, zheng3, fan3, inlet3, drain3,
                   ledzheng3, ledfan3, ledinlet3, leddrain3, ledstop3, alarm3};

    function automatic obs_t mk(input logic [2:0] ph, input int cnt,
                                input logic z, input logic f, input logic in,
                                input logic dr, input logic al);
        return {ph, 8'(cnt), z, f, in, dr, z, f, in, dr, ~(z | f), al};
    endfunction

    task automatic push_run(input logic [2:0] ph, input int dur,
                            input logic z, input logic f, input logic in, input logic dr);
        for (int c = dur; c >= 1; c--) exp_q.push_back(mk(ph, c, z, f, in, dr, 1'b0));
    endtask

    task automatic push_agit(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            push_run(P_AGIT, RUN_S,   1'b1, 1'b0, 1'b0, 1'b0);
            push_run(P_AGIT, PAUSE_S, 1'b0, 1'b0, 1'b0, 1'b0);
            push_run(P_AGIT, RUN_S,   1'b0, 1'b1, 1'b0, 1'b0);
            push_run(P_AGIT, PAUSE_S, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic push_rinse_spin_done();
        for (int r = 0; r < RINSE_N; r++) begin
            push_run(P_FILL, FILL_S, 1'b0, 1'b0, 1'b1, 1'b0);
            push_agit(RINSE_CYC);
            push_run(P_DRAIN, DRAIN_S, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        push_run(P_SPIN, SPIN_S, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk(P_DONE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    // All helpers assume they are entered at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_select();
        select = 1'b1;
        @(negedge clk);
        select = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
        checks++;
        if (obs !== mk(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset: got obs=%h mode=%0d, want obs=%h mode=0",
                     obs, mode, mk(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        checks++;
        if (obs3 !== mk(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) || mode3 !== 2'd0) begin
            errors++;
            $display("FAIL reset3: got obs=%h mode=%0d", obs3, mode3);
        end
    endtask

    task automatic test_select();
        for (int k = 0; k < 5; k++) pulse_select();
        checks++;
        if (mode !== 2'd1) begin
            errors++; $display("FAIL select_wrap: got mode %0d, want 1", mode);
        end
        pulse_start();
        checks++;
        if (phase !== P_FILL) begin
            errors++; $display("FAIL wash_only_start: got phase %0d, want %0d", phase, P_FILL);
        end
        select = 1'b1;
        @(negedge clk);
        select = 1'b0;
        checks++;
        if (mode !== 2'd1 || phase !== P_FILL) begin
            errors++; $display("FAIL select_in_fill: got mode %0d phase %0d, want 1 %0d", mode, phase, P_FILL);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_spin_only();
        for (int k = 0; k < 3; k++) pulse_select();
        checks++;
        if (mode !== 2'd3) begin
            errors++; $display("FAIL mode3_sel: got mode %0d, want 3", mode);
        end
        push_run(P_SPIN, SPIN_S, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk(P_DONE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        pulse_start();
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            checks++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL spin_only: got %h, want %h", obs, exp_o);
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        pulse_start();
        checks++;
        if (obs !== mk(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL done_ack: got %h, want idle", obs);
        end
    endtask

    task automatic test_full_program();
        int idx, done_at;
        pulse_select();
        checks++;
        if (mode !== 2'd0) begin
            errors++; $display("FAIL mode_wrap0: got mode %0d, want 0", mode);
        end
        push_run(P_FILL, FILL_S, 1'b0, 1'b0, 1'b1, 1'b0);
        push_agit(WASH_CYC);
        push_run(P_DRAIN, DRAIN_S, 1'b0, 1'b0, 1'b0, 1'b1);
        push_rinse_spin_done();
        pulse_start();
        idx = 0; done_at = -1;
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            checks++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL full_prog cyc %0d: got %h, want %h", idx, obs, exp_o);
            end
            if (alarm === 1'b1 && done_at < 0) done_at = idx;
            idx++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (done_at !== FULL_LEN) begin
            errors++; $display("FAIL full_runtime: alarm at %0d, want %0d", done_at, FULL_LEN);
        end
        pulse_start();
    endtask

    task automatic test_emergency();
        int idx, done_at, halt_n;
        emergency = 1'b1;
        @(negedge clk);
        emergency = 1'b0;
        checks++;
        if (phase !== P_IDLE) begin
            errors++; $display("FAIL emerg_idle: got phase %0d, want 0", phase);
        end
        push_run(P_FILL, FILL_S, 1'b0, 1'b0, 1'b1, 1'b0);
        push_run(P_AGIT, RUN_S, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.pop_back();   // replace the final F entry (count 1) with the halt window
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(P_HALT, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push_run(P_AGIT, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push_run(P_AGIT, PAUSE_S, 1'b0, 1'b0, 1'b0, 1'b0);
        push_run(P_AGIT, RUN_S,   1'b0, 1'b1, 1'b0, 1'b0);
        push_run(P_AGIT, PAUSE_S, 1'b0, 1'b0, 1'b0, 1'b0);
        push_run(P_DRAIN, DRAIN_S, 1'b0, 1'b0, 1'b0, 1'b1);
        push_rinse_spin_done();
        pulse_start();
        idx = 0; done_at = -1; halt_n = 0;
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            checks++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL emergency cyc %0d: got %h, want %h", idx, obs, exp_o);
            end
            if (phase === P_HALT) halt_n++;
            if (alarm === 1'b1 && done_at < 0) done_at = idx;
            case (idx)
                3: emergency = 1'b1;   // first forward run showing count 2
                5: start = 1'b1;       // must be ignored while emergency high
                6: start = 1'b0;
                7: emergency = 1'b0;
                8: start = 1'b1;       // resume
                9: start = 1'b0;
                default: ;
            endcase
            idx++;
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (done_at !== FULL_LEN + halt_n + 1 || halt_n !== 5) begin
            errors++; $display("FAIL halt_runtime: alarm at %0d halt %0d, want %0d halt 5",
                               done_at, halt_n, FULL_LEN + 6);
        end
        pulse_start();
    endtask

    task automatic test_reset_mid_drain();
        pulse_select();
        pulse_select();
        checks++;
        if (mode !== 2'd2) begin
            errors++; $display("FAIL mode2_sel: got mode %0d, want 2", mode);
        end
        push_run(P_FILL, FILL_S, 1'b0, 1'b0, 1'b1, 1'b0);
        push_agit(RINSE_CYC);
        exp_q.push_back(mk(P_DRAIN, DRAIN_S, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        pulse_start();
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            checks++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL rinse_run: got %h, want %h", obs, exp_o);
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs !== mk(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) || mode !== 2'd0) begin
            errors++; $display("FAIL reset_mid_drain: got %h mode %0d, want idle mode 0", obs, mode);
        end
    endtask

    task automatic test_prescaler();
        for (int c = FILL_S; c >= 1; c--)
            for (int k = 0; k < 3; k++) exp_q.push_back(mk(P_FILL, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(P_AGIT, RUN_S, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            checks++;
            if (obs3 !== exp_o) begin
                errors++; $display("FAIL prescaler: got %h, want %h", obs3, exp_o);
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; select = 1'b0; emergency = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; select3 = 1'b0; emergency3 = 1'b0;
        @(negedge clk);
        test_reset();
        test_select();
        test_spin_only();
        test_full_program();
        test_emergency();
        test_reset_mid_drain();
        test_prescaler();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
